// File: rtl/pb_debounce_onepulse_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encodings and
// default parameter values used by tops and testbenches alike.
package pb_debounce_onepulse_pkg;

    localparam int unsigned DefSyncStages     = 2;
    localparam int unsigned DefDebounceCycles = 16;

    typedef enum logic [1:0] {
        StIdle        = 2'b00,
        StPressWait   = 2'b01,
        StPressed     = 2'b10,
        StReleaseWait = 2'b11
    } pb_state_e;

endpackage

// File: rtl/pb_debounce_onepulse_sync.sv
// Multi-flop synchroniser bringing the asynchronous button line into the clk domain.
// All stages clear asynchronously on reset.
module pb_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pb_debounce_onepulse.sv
// Push-button conditioner: synchronise, debounce, and emit one-cycle press and
// release pulses alongside the debounced level. All outputs are registered.
module pb_debounce_onepulse
    import pb_debounce_onepulse_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DefSyncStages,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_in,
    output logic pb_level,
    output logic pb_pulse,
    output logic pb_release
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic             w_ps;
    pb_state_e        r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_level, r_pulse, r_release;
    logic             w_level_d, w_pulse_d, w_release_d;

    pb_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .i_d(pb_in),
        .o_q(w_ps)
    );

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_pulse_d   = 1'b0;
        w_release_d = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_ps) begin
                    w_state_d = StPressWait;
                    w_cnt_d   = CntOne;
                end
            end
            StPressWait: begin
                if (!w_ps) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else if (r_cnt == CntLast) begin
                    w_state_d = StPressed;
                    w_cnt_d   = '0;
                    w_pulse_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + CntOne;
                end
            end
            StPressed: begin
                if (!w_ps) begin
                    w_state_d = StReleaseWait;
                    w_cnt_d   = CntOne;
                end
            end
            StReleaseWait: begin
                if (w_ps) begin
                    w_state_d = StPressed;
                    w_cnt_d   = '0;
                end else if (r_cnt == CntLast) begin
                    w_state_d   = StIdle;
                    w_cnt_d     = '0;
                    w_release_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + CntOne;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Level follows the state being entered so it rises with the press pulse.
    assign w_level_d = (w_state_d == StPressed) || (w_state_d == StReleaseWait);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_pulse   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_level   <= w_level_d;
            r_pulse   <= w_pulse_d;
            r_release <= w_release_d;
        end
    end

    assign pb_level   = r_level;
    assign pb_pulse   = r_pulse;
    assign pb_release = r_release;

endmodule

// File: tb/tb_pb_debounce_onepulse.sv
// Bench for pb_debounce_onepulse: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed latencies.
module tb_pb_debounce_onepulse;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DC   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pb_in = 1'b0;
    logic pb_level, pb_pulse, pb_release;

    int total = 0;
    int bad   = 0;

    pb_debounce_onepulse #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pb_in(pb_in),
        .pb_level(pb_level),
        .pb_pulse(pb_pulse),
        .pb_release(pb_release)
    );

    always #5 clk = ~clk;

    // Model: the accepted level flips once DC consecutive synchronised samples
    // disagree with it; any agreeing sample resets the run.
    logic [SYNC-1:0] m_sh = '0;
    logic            m_lvl = 1'b0;
    logic            m_pulse = 1'b0;
    logic            m_rel = 1'b0;
    int              m_run = 0;
    logic            m_ps;
    int              m_next_run;

    assign m_ps       = m_sh[SYNC-1];
    assign m_next_run = (m_ps != m_lvl) ? m_run + 1 : 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_sh    <= '0;
            m_lvl   <= 1'b0;
            m_run   <= 0;
            m_pulse <= 1'b0;
            m_rel   <= 1'b0;
        end else begin
            m_sh    <= {m_sh[SYNC-2:0], pb_in};
            m_pulse <= 1'b0;
            m_rel   <= 1'b0;
            if (m_next_run == int'(DC)) begin
                m_lvl   <= ~m_lvl;
                m_pulse <= ~m_lvl;
                m_rel   <= m_lvl;
                m_run   <= 0;
            end else begin
                m_run <= m_next_run;
            end
        end
    end

    always @(negedge clk) begin
        total++;
        if ({pb_level, pb_pulse, pb_release} !== {m_lvl, m_pulse, m_rel}) begin
            bad++;
            $display("FAIL model_cmp t=%0t: got lvl/pulse/rel=%b%b%b want %b%b%b", $time,
                     pb_level, pb_pulse, pb_release, m_lvl, m_pulse, m_rel);
        end
    end

    // Downstream toggle FSM stand-in.
    logic sel_out = 1'b0;
    always @(negedge clk or negedge rst) begin
        if (!rst) sel_out <= 1'b0;
        else if (pb_pulse) sel_out <= ~sel_out;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Counts edges until the requested pulse; n=-1 if the budget expires.
    task automatic wait_evt(input bit rel, output int n, output int other);
        n = -1;
        other = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rel ? pb_release : pb_pulse) begin
                n = i;
                return;
            end
            if (rel ? pb_pulse : pb_release) other++;
        end
    endtask

    task automatic quiet_win(input int cycles, output int pulses, output int rels,
                             output int lvl_hi);
        pulses = 0;
        rels = 0;
        lvl_hi = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            pulses += int'(pb_pulse);
            rels   += int'(pb_release);
            lvl_hi += int'(pb_level);
        end
    endtask

    int n, o, p, r, l;
    logic [4:0] bounce;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({pb_level, pb_pulse, pb_release}), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Clean press, no auto-repeat, then release.
        pb_in = 1'b1;
        wait_evt(1'b0, n, o);
        chk("press_latency", n, 6);
        chk("press_level", int'(pb_level), 1);
        quiet_win(14, p, r, l);
        chk("held_no_repeat", p, 0);
        chk("held_level", l, 14);
        pb_in = 1'b0;
        wait_evt(1'b1, n, o);
        chk("release_latency", n, 6);
        chk("release_level", int'(pb_level), 0);
        chk("release_no_pulse", o, 0);
        quiet_win(8, p, r, l);

        // Bounce 1,0,1,1,0 then held high.
        bounce = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            pb_in = bounce[i];
            @(negedge clk);
        end
        pb_in = 1'b1;
        wait_evt(1'b0, n, o);
        chk("bounce_latency", n, 6);
        pb_in = 1'b0;
        wait_evt(1'b1, n, o);
        chk("bounce_release", n, 6);
        quiet_win(6, p, r, l);

        // Three-cycle glitch.
        pb_in = 1'b1;
        repeat (3) @(negedge clk);
        pb_in = 1'b0;
        quiet_win(20, p, r, l);
        chk("glitch_pulse", p, 0);
        chk("glitch_release", r, 0);
        chk("glitch_level", l, 0);

        // Reset in the middle of the press wait.
        pb_in = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_mid_outputs", int'({pb_level, pb_pulse, pb_release}), 0);
        end
        rst = 1'b1;
        wait_evt(1'b0, n, o);
        chk("post_reset_latency", n, 6);
        pb_in = 1'b0;
        wait_evt(1'b1, n, o);
        quiet_win(4, p, r, l);

        // Chain with toggle FSM.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("sel_initial", int'(sel_out), 0);
        for (int k = 1; k <= 3; k++) begin
            pb_in = 1'b1;
            wait_evt(1'b0, n, o);
            @(negedge clk);
            chk("sel_after_press", int'(sel_out), k % 2);
            pb_in = 1'b0;
            wait_evt(1'b1, n, o);
            @(negedge clk);
            chk("sel_after_release", int'(sel_out), k % 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
